// File: rtl/ahb_slv_pkg.sv
// Shared types and constants for the AHB SRAM slave.
// The optional wait-state feature is enabled by defining AHB_SLV_WAIT_EN.
package ahb_slv_pkg;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef logic [1:0] slv_state_t;
  localparam slv_state_t S_IDLE = 2'd0;
  localparam slv_state_t S_DATA = 2'd1;
  localparam slv_state_t S_ERR1 = 2'd2;
  localparam slv_state_t S_ERR2 = 2'd3;

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-wide SRAM array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ahb_slv_mem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] ridx,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave exposing a word-addressed SRAM window at BASE_ADDR, two-cycle ERROR on illegal access.
// Define AHB_SLV_WAIT_EN to insert WAIT_ST wait states into every legal data phase.
module ahb_sram_slave
  import ahb_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WAIT_ST   = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADYin,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  slv_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_q, wr_d;
  logic              hready_q, hready_d;
  hresp_t            hresp_q, hresp_d;
  logic [31:0]       offset_c;
  logic              accept_c, legal_c, ready_c, we_c;
  logic              waiting_c, wait_next_c;
  logic [31:0]       rdata_c;

  assign offset_c = HADDR - BASE_ADDR;
  assign accept_c = HSEL & HREADYin & HTRANS[1];
  assign legal_c  = (offset_c < WIN_BYTES) && (HADDR[1:0] == 2'b00) && (HSIZE == HSIZE_WORD);

  // Current data phase (or idle slot) closes on this edge.
  assign ready_c = (state_q != S_ERR1) && !waiting_c;

`ifdef AHB_SLV_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_ST > 0) ? $clog2(WAIT_ST + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign waiting_c   = (state_q == S_DATA) && (cnt_q != '0);
  assign wait_next_c = (cnt_d != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (waiting_c) cnt_d = cnt_q - CNT_W'(1);
    else if (ready_c && accept_c && legal_c) cnt_d = CNT_W'(WAIT_ST);
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_wait;
  assign unused_wait = ^32'(WAIT_ST);
  assign waiting_c   = 1'b0;
  assign wait_next_c = 1'b0;
`endif

  // Sequencing follows HTRANS/HADDR only; burst and protection hints carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{HTRANS[0], HBURST, HPROT};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    hready_d = 1'b1;
    hresp_d  = OKAY;
    if (ready_c) begin
      if (accept_c) begin
        state_d = legal_c ? S_DATA : S_ERR1;
        idx_d   = offset_c[ADDR_W+1:2];
        wr_d    = HWRITE;
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end
    hready_d = (state_d != S_ERR1) && !wait_next_c;
    hresp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? ERROR : OKAY;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= OKAY;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Write lands on the edge that ends the data phase, so a following read already sees it.
  assign we_c = (state_q == S_DATA) && wr_q && !waiting_c;

  ahb_slv_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (HCLK),
    .we    (we_c),
    .widx  (idx_q),
    .wdata (HWDATA),
    .ridx  (idx_q),
    .rdata (rdata_c)
  );

  assign HREADY = hready_q;
  assign HRESP  = hresp_q;
  assign HRDATA = ((state_q == S_DATA) && !wr_q) ? rdata_c : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed steps plus random traffic against a word-array model.
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0]  SZ_W  = 3'b010;
`ifdef AHB_SLV_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADYin, HWRITE;
  logic [1:0]  HTRANS, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY;

  assign HREADYin = HREADY;

  ahb_sram_slave #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_ST(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADYin(HREADYin), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];

  // Transfer currently occupying (or about to occupy) the data phase.
  logic        ph_valid = 1'b0, ph_legal = 1'b0, ph_write = 1'b0;
  int          ph_idx = 0;
  logic [31:0] ph_wdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one address phase while checking the previous transfer's data phase to completion.
  task automatic step(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic wr, input logic [2:0] size, input logic [31:0] wd);
    int          waits;
    logic        done;
    logic [31:0] off;
    HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    HBURST = 3'($urandom); HPROT = 4'($urandom); HWDATA = $urandom;
    waits = !ph_valid ? 0 : (ph_legal ? WAITS : 1);
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge HCLK);
      check("hready", {31'b0, HREADY}, 32'(k >= waits));
      check("hresp", {30'b0, HRESP}, (ph_valid && !ph_legal) ? 32'h1 : 32'h0);
      if (ph_valid && !ph_write)
        check("hrdata", HRDATA, ph_legal ? ref_mem[ph_idx] : 32'h0);
      done = (HREADY === 1'b1);
      HWDATA = (k < waits) ? $urandom : ph_wdata;
    end
    check("phase_end", {31'b0, done}, 32'h1);
    @(posedge HCLK); #1;
    if (ph_valid && ph_legal && ph_write) ref_mem[ph_idx] = ph_wdata;
    off      = addr - BASE;
    ph_valid = sel && trans[1];
    ph_legal = (off < DEPTH * 4) && (addr[1:0] == 2'b00) && (size == SZ_W);
    ph_write = wr;
    ph_idx   = int'(off[AW+1:2]);
    ph_wdata = wd;
  endtask

  task automatic idle_step();
    step(1'b0, T_IDLE, BASE, 1'b0, SZ_W, 32'h0);
  endtask

  // Start a write and pull reset low inside its data phase.
  task automatic reset_mid(input string tag, input logic [31:0] addr, input logic [2:0] size);
    step(1'b1, T_NSEQ, addr, 1'b1, size, 32'h5A5A_0F0F);
    HSEL = 1'b0; HTRANS = T_IDLE;
    #1 HRESET = 1'b0;
    #1;
    check({tag, "_hready"}, {31'b0, HREADY}, 32'h1);
    check({tag, "_hresp"}, {30'b0, HRESP}, 32'h0);
    check({tag, "_hrdata"}, HRDATA, 32'h0);
    ph_valid = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish within time limit");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b0; HSEL = 1'b0; HTRANS = T_IDLE; HADDR = BASE; HWRITE = 1'b0;
    HSIZE = SZ_W; HBURST = 3'b0; HPROT = 4'b0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hready", {31'b0, HREADY}, 32'h1);
    check("rst_hresp", {30'b0, HRESP}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    idle_step();
    step(1'b1, T_BUSY, BASE, 1'b1, SZ_W, 32'h0);
    idle_step();

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, (i == 0) ? T_NSEQ : T_SEQ, BASE + 32'(i * 4), 1'b1, SZ_W, $urandom);

    // Write then immediately read the same word.
    step(1'b1, T_NSEQ, BASE + 32'h10, 1'b1, SZ_W, 32'hDEAD_BEEF);
    step(1'b1, T_NSEQ, BASE + 32'h10, 1'b0, SZ_W, 32'h0);
    idle_step();
    check("deadbeef_model", ref_mem[4], 32'hDEAD_BEEF);

    // INCR4 write burst then INCR4 read burst.
    for (int i = 0; i < 4; i++)
      step(1'b1, (i == 0) ? T_NSEQ : T_SEQ, BASE + 32'(i * 4), 1'b1, SZ_W, 32'(i + 1));
    for (int i = 0; i < 4; i++)
      step(1'b1, (i == 0) ? T_NSEQ : T_SEQ, BASE + 32'(i * 4), 1'b0, SZ_W, 32'h0);
    idle_step();

    // Illegal accesses, each followed by a readback of the word it might have hit.
    step(1'b1, T_NSEQ, BASE + 32'h02, 1'b1, SZ_W, 32'hBAD0_0002);
    step(1'b1, T_NSEQ, BASE + 32'h00, 1'b0, SZ_W, 32'h0);
    step(1'b1, T_NSEQ, BASE + 32'h04, 1'b1, 3'b000, 32'hBAD0_0004);
    step(1'b1, T_NSEQ, BASE + 32'h04, 1'b0, SZ_W, 32'h0);
    step(1'b1, T_NSEQ, BASE + 32'(DEPTH * 4), 1'b1, SZ_W, 32'hBAD0_0040);
    step(1'b1, T_NSEQ, BASE + 32'h00, 1'b0, SZ_W, 32'h0);
    step(1'b1, T_NSEQ, BASE + 32'h02, 1'b0, SZ_W, 32'h0);
    step(1'b1, T_NSEQ, BASE + 32'h3C, 1'b1, SZ_W, 32'hC0DE_003C);
    step(1'b1, T_SEQ,  BASE + 32'h40, 1'b1, SZ_W, 32'hBAD0_0041);
    step(1'b1, T_NSEQ, BASE + 32'h3C, 1'b0, SZ_W, 32'h0);
    idle_step();
    check("ref_word0", ref_mem[0], 32'h1);
    check("ref_word1", ref_mem[1], 32'h2);

    // Random mix of legal, illegal and idle slots.
    for (int n = 0; n < 200; n++) begin
      int          r;
      logic [31:0] a;
      logic [2:0]  sz;
      r  = $urandom_range(0, 9);
      a  = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
      sz = SZ_W;
      if (r == 0) begin
        step(1'b0, 2'($urandom), a, 1'($urandom), sz, $urandom);
      end else if (r == 1) begin
        step(1'b1, 2'($urandom_range(0, 1)), a, 1'($urandom), sz, $urandom);
      end else if (r == 2) begin
        case ($urandom_range(0, 3))
          0: a = a + 32'($urandom_range(1, 3));
          1: sz = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b011;
          2: a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63)) * 4;
          default: a = BASE - 32'h4;
        endcase
        step(1'b1, T_NSEQ, a, 1'($urandom), sz, $urandom);
      end else begin
        step(1'b1, r[0] ? T_SEQ : T_NSEQ, a, 1'($urandom), SZ_W, $urandom);
      end
    end
    idle_step();

    // Reset during a legal write, then during an ERROR response.
    reset_mid("rst_write", BASE + 32'h20, SZ_W);
    step(1'b1, T_NSEQ, BASE + 32'h20, 1'b0, SZ_W, 32'h0);
    idle_step();
    reset_mid("rst_err", BASE + 32'h24, 3'b000);
    step(1'b1, T_NSEQ, BASE + 32'h24, 1'b0, SZ_W, 32'h0);
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
